// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encoding, default sizes
// and the per-mode initial pattern.
package led_pkg;

    localparam int DEF_N_LED = 8;
    localparam int DEF_PWM_W = 4;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    // Every initial pattern is either all-zero or a lone LSB, so only that bit varies.
    function automatic logic init_lsb(input mode_e m);
        return (m == MODE_WALK) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control/drive bundle between the tick divider side and the LED sequencer.
interface led_pattern_seq_if #(
    parameter int N_LED = led_pkg::DEF_N_LED,
    parameter int PWM_W = led_pkg::DEF_PWM_W
);
    logic             tick;
    logic             en;
    logic [1:0]       mode;
    logic [PWM_W-1:0] brightness;
    logic [N_LED-1:0] led;
    logic             wrap;

    modport master (output tick, en, mode, brightness, input led, wrap);
    modport slave  (input tick, en, mode, brightness, output led, wrap);
endinterface

// File: rtl/led_pwm.sv
// Free-running PWM counter with a duty level latched only at the start of each period.
module led_pwm
    import led_pkg::*;
#(
    parameter int PWM_W = DEF_PWM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] brightness,
    output logic             pwm_on
);
    // Period is 2^PWM_W-1 so the all-ones brightness code means permanently on.
    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);

    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0] bright_q, bright_d;

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
        bright_d  = (pwm_cnt_q == '0) ? brightness : bright_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            bright_q  <= bright_d;
        end
    end

    assign pwm_on = (pwm_cnt_q < bright_q);

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: BLINK/WALK/BOUNCE/COUNT patterns advanced by a slow tick,
// with a wrap pulse and PWM dimming applied at the registered output.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int N_LED = DEF_N_LED,
    parameter int PWM_W = DEF_PWM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pattern_seq_if.slave  bus
);
    logic [N_LED-1:0] pat_q, pat_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             pwm_on;
    logic             adv;
    logic             pat_onehot;
    mode_e            req_mode;

    function automatic logic [N_LED-1:0] init_vec(input mode_e m);
        return {{(N_LED-1){1'b0}}, init_lsb(m)};
    endfunction

    led_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .brightness(bus.brightness),
        .pwm_on    (pwm_on)
    );

    assign adv        = bus.tick & bus.en;
    assign req_mode   = mode_e'(bus.mode);
    assign pat_onehot = $onehot(pat_q);

    always_comb begin
        pat_d  = pat_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        if (adv) begin
            if (req_mode != mode_q) begin
                mode_d = req_mode;
                pat_d  = init_vec(req_mode);
                dir_d  = 1'b0;
            end else begin
                unique case (mode_q)
                    MODE_BLINK: begin
                        pat_d  = ~pat_q;
                        wrap_d = &pat_q;
                    end
                    MODE_WALK: begin
                        if (!pat_onehot) begin
                            pat_d = init_vec(MODE_WALK);
                        end else begin
                            pat_d  = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
                            wrap_d = pat_q[N_LED-1];
                        end
                    end
                    MODE_BOUNCE: begin
                        if (!dir_q && pat_onehot && !pat_q[N_LED-1]) begin
                            pat_d = pat_q << 1;
                            dir_d = pat_q[N_LED-2];
                        end else if (dir_q && pat_onehot && !pat_q[0]) begin
                            pat_d  = pat_q >> 1;
                            dir_d  = ~pat_q[1];
                            wrap_d = pat_q[1];
                        end else begin
                            // Corrupt pattern, or direction pointing off the end: restart.
                            pat_d = init_vec(MODE_BOUNCE);
                            dir_d = 1'b0;
                        end
                    end
                    MODE_COUNT: begin
                        pat_d  = pat_q + N_LED'(1);
                        wrap_d = &pat_q;
                    end
                    default: ;
                endcase
            end
        end
        led_d = pat_q & {N_LED{pwm_on}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= '0;
            mode_q <= MODE_BLINK;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            led_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: hand-written vector table, directed
// corner sequences and randomized traffic against a step-count reference model.
module tb_led_pattern_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_pattern_seq_if #(.N_LED(8), .PWM_W(4)) bus ();

    led_pattern_seq #(.N_LED(8), .PWM_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pattern is a pure function of (mode, advances since load).
    int         m_mode, m_step, m_cyc, m_bright;
    logic [7:0] exp_led;
    logic       exp_wrap;

    function automatic int period(input int md);
        case (md)
            0: return 2;
            1: return 8;
            2: return 14;
            default: return 256;
        endcase
    endfunction

    function automatic logic [7:0] model_pat(input int md, input int st);
        int k;
        case (md)
            0: return (st % 2 == 1) ? 8'hFF : 8'h00;
            1: return 8'(1 << (st % 8));
            2: begin
                k = st % 14;
                return 8'(1 << ((k < 8) ? k : 14 - k));
            end
            default: return 8'(st % 256);
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_cyc = 0; m_bright = 0;
        exp_led = 8'h00; exp_wrap = 1'b0;
    endtask

    task automatic model_edge();
        logic on;
        on      = (m_cyc % 15) < m_bright;
        exp_led = model_pat(m_mode, m_step) & {8{on}};
        if (m_cyc % 15 == 0) m_bright = int'(bus.brightness);
        m_cyc++;
        exp_wrap = 1'b0;
        if (bus.tick && bus.en) begin
            if (int'(bus.mode) != m_mode) begin
                m_mode = int'(bus.mode);
                m_step = 0;
            end else begin
                m_step++;
                exp_wrap = (m_step % period(m_mode)) == 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: model consumes inputs at the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("led", 32'(bus.led), 32'(exp_led));
        chk("wrap", 32'(bus.wrap), 32'(exp_wrap));
    endtask

    task automatic tick1(input logic en_v);
        bus.en = en_v;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        bus.en = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] exp_pat;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs [25];
    logic [7:0] pat_tab [25] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01,
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    task automatic apply_vec(input int i);
        bus.mode = vecs[i].mode;
        tick1(1'b1);
        chk($sformatf("vec%0d_wrap", i), 32'(bus.wrap), 32'(vecs[i].exp_wrap));
        cyc();
        chk($sformatf("vec%0d_led", i), 32'(bus.led), 32'(vecs[i].exp_pat));
        $display("vec %0d mode=%0d led=%02h expect=%02h wrap_exp=%0b",
                 i, vecs[i].mode, bus.led, vecs[i].exp_pat, vecs[i].exp_wrap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int wraps, on_cnt;

        for (int i = 0; i < 25; i++) begin
            vecs[i].mode     = (i < 9) ? 2'd1 : 2'd2;
            vecs[i].exp_pat  = pat_tab[i];
            vecs[i].exp_wrap = (i == 8) || (i == 23);
        end

        bus.tick = 1'b0; bus.en = 1'b1; bus.mode = 2'd1; bus.brightness = 4'd15;
        model_reset();
        do_reset();
        chk("reset_led", 32'(bus.led), 32'h0);
        chk("reset_wrap", 32'(bus.wrap), 32'h0);
        chk("reset_pat", 32'(dut.pat_q), 32'h0);
        repeat (2) cyc();

        // WALK from reset, then BOUNCE after a mode change
        for (int i = 0; i < 25; i++) apply_vec(i);

        // COUNT: load, then 256 back-to-back advances with exactly one wrap
        bus.mode = 2'd3;
        tick1(1'b1);
        wraps = 0;
        bus.tick = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (bus.wrap) wraps++;
        end
        bus.tick = 1'b0;
        chk("count_last_wrap", 32'(bus.wrap), 32'h1);
        chk("count_wraps", 32'(wraps), 32'd1);
        cyc();
        chk("count_led", 32'(bus.led), 32'h00);

        // BLINK at FF under dimming levels
        bus.mode = 2'd0;
        tick1(1'b1);
        tick1(1'b1);
        chk("blink_first_wrap", 32'(bus.wrap), 32'h0);
        bus.brightness = 4'd5;
        repeat (30) cyc();
        on_cnt = 0;
        for (int i = 0; i < 15; i++) begin cyc(); if (bus.led == 8'hFF) on_cnt++; end
        chk("duty5", 32'(on_cnt), 32'd5);
        while (m_cyc % 15 != 7) cyc();
        bus.brightness = 4'd10;
        on_cnt = 0;
        for (int i = 0; i < 15; i++) begin cyc(); if (bus.led == 8'hFF) on_cnt++; end
        chk("duty_change_mid", 32'(on_cnt), 32'd7);
        bus.brightness = 4'd15;
        repeat (30) cyc();
        on_cnt = 0;
        for (int i = 0; i < 15; i++) begin cyc(); if (bus.led == 8'hFF) on_cnt++; end
        chk("duty15", 32'(on_cnt), 32'd15);
        bus.brightness = 4'd0;
        repeat (30) cyc();
        on_cnt = 0;
        for (int i = 0; i < 15; i++) begin cyc(); if (bus.led != 8'h00) on_cnt++; end
        chk("duty0", 32'(on_cnt), 32'd0);

        // WALK to 10, dropped tick, then enabled tick into COUNT
        bus.brightness = 4'd15;
        repeat (30) cyc();
        bus.mode = 2'd1;
        repeat (5) tick1(1'b1);
        cyc();
        chk("walk_10", 32'(bus.led), 32'h10);
        tick1(1'b0);
        cyc();
        chk("en0_hold", 32'(bus.led), 32'h10);
        bus.mode = 2'd3;
        tick1(1'b1);
        chk("modechg_wrap", 32'(bus.wrap), 32'h0);
        chk("modechg_mode_q", 32'(dut.mode_q), 32'd3);
        cyc();
        chk("modechg_led", 32'(bus.led), 32'h00);

        // Asynchronous reset mid-BOUNCE on the way down at 20
        bus.mode = 2'd2;
        repeat (10) tick1(1'b1);
        cyc();
        chk("bounce_20", 32'(bus.led), 32'h20);
        chk("bounce_dir", 32'(dut.dir_q), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", 32'(bus.led), 32'h0);
        chk("async_wrap", 32'(bus.wrap), 32'h0);
        chk("async_pat", 32'(dut.pat_q), 32'h0);
        chk("async_mode", 32'(dut.mode_q), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) cyc();
        for (int i = 0; i < 9; i++) apply_vec(i);

        // Randomized traffic against the reference model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) bus.brightness = 4'($urandom_range(0, 15));
            bus.tick = ($urandom_range(0, 3) == 0);
            bus.en   = ($urandom_range(0, 9) != 0);
            cyc();
        end
        bus.tick = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

- Drives the board LEDs D1–D8 with a pattern that advances on a slow tick strobe.
- The tick comes from the upstream half-second divider. It is one `clk` cycle wide, nominally once per 6 M cycles at 12 MHz.
- Four pattern modes are supported, each with a wrap indicator, and global PWM dimming is applied on top.
- The block sits between the tick divider and the LED output pins.

## Interface
Parameters:
- `N_LED`, default 8: number of LED outputs; must be ≥ 2.
- `PWM_W`, default 4: width of `brightness` and of the PWM counter.

Ports:
- `clk` in 1: system clock, 12 MHz.
- `rst_n` in 1: reset, asynchronous, active-low. Deassertion is synchronised externally.
- `tick` in 1: single-cycle advance strobe.
- `en` in 1: when 0, `tick` is ignored and the pattern is held.
- `mode` in 2: requested mode.
  - 0 BLINK
  - 1 WALK
  - 2 BOUNCE
  - 3 COUNT
- `brightness` in PWM_W: duty level.
  - 0 = always off.
  - `2^PWM_W−1` = always on.
- `led` out N_LED: registered LED drive, active-high.
- `wrap` out 1: one-cycle pulse when the pattern returns to its initial value.

## Operation
- State registers:
  - `pat[N_LED-1:0]`
  - `mode_q[1:0]`
  - `dir`: 0 = up (toward MSB), 1 = down
  - `pwm_cnt[PWM_W-1:0]`
  - `bright_q[PWM_W-1:0]`
  - `led`, `wrap`
- Advance event: `adv = tick & en`. When `adv` = 0, `pat`, `dir` and `mode_q` hold.
- On `adv` with `mode != mode_q` (mode change):
  - `mode_q <= mode`.
  - `pat <= INIT(mode)`.
  - `dir <= 0`.
  - No `wrap` pulse.
- On `adv` with `mode == mode_q`, `pat` advances as follows:
  - BLINK: INIT = all-zeros; `pat <= ~pat`. `wrap` when the new `pat` is all-zeros.
  - WALK: INIT = `…0001`; rotate left by 1, MSB wraps to LSB. `wrap` on the MSB→LSB step.
  - BOUNCE: INIT = `…0001`.
    - `dir`=0: shift left. On reaching the MSB, set `dir`=1.
    - `dir`=1: shift right. On reaching the LSB, set `dir`=0 and pulse `wrap`.
    - Period is `2·N_LED−2` ticks; each end value appears once per period.
  - COUNT: INIT = 0; `pat <= pat + 1`, modulo `2^N_LED`. `wrap` on the all-ones → 0 step.
- Illegal `pat` (possible only after SEU): WALK/BOUNCE with `pat` not one-hot loads INIT on the next advance, with no `wrap`.
- PWM:
  - `pwm_cnt` runs freely, 0 → `2^PWM_W−2`, then wraps to 0. Period is `2^PWM_W−1` cycles (15 for the default).
  - `bright_q <= brightness` only when `pwm_cnt == 0`, so a duty change never splits a PWM period.
  - `pwm_on = (pwm_cnt < bright_q)`.
  - `led <= pat & {N_LED{pwm_on}}`.
- Reset values (all outputs and state):
  - `pat` = 0, `mode_q` = 0 (BLINK), `dir` = 0.
  - `pwm_cnt` = 0, `bright_q` = 0.
  - `led` = 0, `wrap` = 0.

## Timing
- `tick` sampled high at edge N:
  - `pat` and `wrap` update at edge N (visible in cycle N+1).
  - `led` reflects the new `pat` at edge N+1, gated by `pwm_on`.
- `wrap` is high for exactly one cycle per wrapping advance. Back-to-back ticks may produce back-to-back `wrap` pulses.
- `mode` and `brightness` are quasi-static. `mode` is sampled only on `adv`; `brightness` only at `pwm_cnt` = 0.
- `en` falling in the same cycle as `tick`: the tick is dropped.
- Reset asserted mid-pattern: all registers clear immediately, without waiting for `clk`. `led` goes to 0 asynchronously.
- First advance after reset: if `mode` ≠ BLINK, INIT is loaded. If `mode` is BLINK, `pat` goes 0 → all-ones with no `wrap`.

## Structure
- Shared package `led_pkg`:
  - Mode constants `MODE_BLINK`, `MODE_WALK`, `MODE_BOUNCE`, `MODE_COUNT`.
  - `INIT` function.
  - Default `N_LED` / `PWM_W`.
- Sub-module `led_pwm`: owns `pwm_cnt`, `bright_q` and `pwm_on`. Ports: `clk`, `rst_n`, `brightness`, `pwm_on`.
- The top level owns the pattern FSM, the `wrap` logic and the output register.

## Test plan
1. Reset with `mode`=1, `brightness`=15, `en`=1, then 9 ticks.
   - `pat` sequence: 01, 02, 04, …, 80, 01.
   - The first tick loads 01 with no `wrap`; `wrap` pulses once on 80→01.
   - `led` equals `pat` every cycle.
2. `mode`=2, 15 ticks after the mode-change load.
   - Sequence: 01, 02, …, 80, 40, …, 01.
   - `wrap` pulses only on 02→01, period 14 ticks.
3. `mode`=3, 256 ticks.
   - `pat` counts 00 → FF → 00.
   - Exactly one `wrap`, on the 256th advance.
4. `mode`=0 with `brightness`=5, then 15, then 0.
   - `brightness`=5, `pat`=FF: `led`=FF for exactly 5 of every 15 cycles.
   - `brightness`=15: `led` is constant FF.
   - `brightness`=0: `led` is constant 00.
   - Changing `brightness` from 5 to 10 mid-period: the new duty starts only at the next `pwm_cnt`=0.
5. WALK at `pat`=10; pulse `tick` with `en`=0, then switch `mode` to 3 and tick with `en`=1.
   - With `en`=0: `pat` stays 10.
   - On the enabled tick: `pat`=00, `mode_q`=3, no `wrap`.
6. Assert `rst_n` low mid-BOUNCE (`dir`=1, `pat`=20), between clock edges.
   - `led`, `wrap` and `pat` clear to 0 before the next `clk` edge.
   - After release, behaviour matches a fresh reset.
